branch_unit: RTL and testbench

Execute-stage branch resolution unit for the RV64 core. It consumes the comparator's `cmp_res` together with the EX-stage control-transfer decode, computes the actual next PC, and produces a registered redirect/flush to fetch. It keeps a small bimodal branch history table (BHT) that fetch reads for its taken prediction, updates the table on every resolved conditional branch, and counts resolved and mispredicted branches.

---
 rtl/branch_unit_if.sv | 43 ++++
 rtl/branch_unit.sv | 131 +++++++++++++
 tb/tb_branch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_unit_if                                                       |
// | EX-stage resolve inputs, fetch BHT lookup, redirect and statistics   |
// | outputs of the branch unit, bundled as one interface.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface branch_unit_if #(
  parameter int CNT_W = 32
);
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jal;
  logic             ex_is_jalr;
  logic [63:0]      ex_pc;
  logic [63:0]      ex_imm;
  logic [63:0]      ex_rs1;
  logic             cmp_res;
  logic             ex_pred_taken;
  logic             stall;
  logic [63:0]      if_pc;
  logic             if_pred_taken;
  logic             redirect_valid;
  logic [63:0]      redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  // Pipeline side: drives the EX instruction and fetch PC, observes results.
  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
    output ex_pc, ex_imm, ex_rs1, cmp_res, ex_pred_taken, stall, if_pc,
    input  if_pred_taken, redirect_valid, redirect_pc, flush, br_cnt, miss_cnt
  );

  // Branch unit side.
  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
    input  ex_pc, ex_imm, ex_rs1, cmp_res, ex_pred_taken, stall, if_pc,
    output if_pred_taken, redirect_valid, redirect_pc, flush, br_cnt, miss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_unit                                                          |
// | Execute-stage branch resolution: computes the actual next PC,        |
// | issues a registered redirect/flush, maintains a bimodal BHT and      |
// | counts resolved / mispredicted conditional branches.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_unit #(
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rstn,
  branch_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Decoded control-transfer kind; illegal multi-hot decode resolves
  // with priority jalr > jal > branch.
  logic             is_jalr;
  logic             is_jal;
  logic             is_br;
  logic             resolve;
  logic             taken;
  logic             mispredict;
  logic             do_redirect;
  logic [63:0]      jalr_sum;
  logic [63:0]      target;
  logic [63:0]      fall_thru;

  logic [IDX_W-1:0] ex_idx;
  logic [IDX_W-1:0] if_idx;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_cur;
  logic [1:0]       bht_d;
  logic             bht_we;

  logic             redirect_valid_q;
  logic             redirect_valid_d;
  logic [63:0]      redirect_pc_q;
  logic [63:0]      redirect_pc_d;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0] miss_cnt_d;

  assign is_jalr = bus.ex_is_jalr;
  assign is_jal  = bus.ex_is_jal & ~bus.ex_is_jalr;
  assign is_br   = bus.ex_is_branch & ~bus.ex_is_jal & ~bus.ex_is_jalr;

  // An instruction seen while a redirect is pending is on the wrong path.
  assign resolve    = bus.ex_valid & ~bus.stall & ~redirect_valid_q;
  assign taken      = is_jal | is_jalr | (is_br & bus.cmp_res);
  assign mispredict = is_br & (taken != bus.ex_pred_taken);
  // Fetch never predicts JAL/JALR, so they always redirect.
  assign do_redirect = resolve & (is_jal | is_jalr | mispredict);

  assign jalr_sum  = bus.ex_rs1 + bus.ex_imm;
  assign target    = is_jalr ? (jalr_sum & ~64'h1) : (bus.ex_pc + bus.ex_imm);
  assign fall_thru = bus.ex_pc + 64'd4;

  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign if_idx = bus.if_pc[IDX_W+1:2];

  // Fetch prediction: plain read of the stored counter, no write bypass.
  assign bus.if_pred_taken = bht_q[if_idx][1];

  // Saturating update value for the counter of the resolving branch.
  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_d   = bht_cur;
    bht_we  = resolve & is_br;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  // Redirect hold/clear and statistics next-state.
  always_comb begin
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    br_cnt_d         = br_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    if (redirect_valid_q) begin
      if (!bus.stall) redirect_valid_d = 1'b0;
    end else if (do_redirect) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = taken ? target : fall_thru;
    end
    if (resolve && is_br) begin
      br_cnt_d = br_cnt_q + 1'b1;
      if (mispredict) miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // Redirect and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
      br_cnt_q         <= '0;
      miss_cnt_q       <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      br_cnt_q         <= br_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
    end
  end

  // BHT storage; every counter resets to weakly not-taken.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = redirect_valid_q;
  assign bus.br_cnt         = br_cnt_q;
  assign bus.miss_cnt       = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_branch_unit                                                       |
// | Self-checking bench for branch_unit with a reference model and an    |
// | expected-redirect scoreboard.                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_branch_unit;

  logic clk;
  logic rstn;

  branch_unit_if #(.CNT_W(32)) bus ();

  branch_unit #(.BHT_ENTRIES(16), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  logic [63:0] exp_q[$];
  logic [1:0]  bht_m [16];
  logic [31:0] br_m;
  logic [31:0] miss_m;
  logic        rv_m;
  logic        prev_rv;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
    br_m   = 0;
    miss_m = 0;
    rv_m   = 0;
    exp_q.delete();
  endtask

  task automatic clear_ex();
    bus.ex_valid      = 0;
    bus.ex_is_branch  = 0;
    bus.ex_is_jal     = 0;
    bus.ex_is_jalr    = 0;
    bus.cmp_res       = 0;
    bus.ex_pred_taken = 0;
  endtask

  // Apply the reference behaviour for the current inputs, then clock once.
  task automatic tick();
    bit          res, jalr_k, jal_k, br_k, tk, mis;
    logic [63:0] tgt;
    logic [3:0]  ix;
    res    = bus.ex_valid && !bus.stall && !rv_m;
    jalr_k = bus.ex_is_jalr;
    jal_k  = bus.ex_is_jal && !jalr_k;
    br_k   = bus.ex_is_branch && !jal_k && !jalr_k;
    tk     = jal_k || jalr_k || (br_k && bus.cmp_res);
    mis    = br_k && (tk != bus.ex_pred_taken);
    tgt    = jalr_k ? ((bus.ex_rs1 + bus.ex_imm) & ~64'h1) : (bus.ex_pc + bus.ex_imm);
    ix     = bus.ex_pc[5:2];
    if (rv_m) begin
      if (!bus.stall) rv_m = 0;
    end else if (res && (jal_k || jalr_k || mis)) begin
      rv_m = 1;
      exp_q.push_back(tk ? tgt : bus.ex_pc + 64'd4);
    end
    if (res && br_k) begin
      br_m++;
      if (mis) miss_m++;
      if (tk && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'd1;
      if (!tk && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = conditional branch, 1 = JAL, 2 = JALR
  task automatic issue(input int kind, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] rs1, input bit cmp, input bit pred);
    logic [3:0] ix;
    ix = pc[5:2];
    bus.ex_valid      = 1;
    bus.ex_is_branch  = (kind == 0);
    bus.ex_is_jal     = (kind == 1);
    bus.ex_is_jalr    = (kind == 2);
    bus.ex_pc         = pc;
    bus.ex_imm        = imm;
    bus.ex_rs1        = rs1;
    bus.cmp_res       = cmp;
    bus.ex_pred_taken = pred;
    bus.if_pc         = pc;
    #1;
    check("pred_before_edge", bus.if_pred_taken, bht_m[ix][1]);
    tick();
    clear_ex();
    check("redirect_valid", bus.redirect_valid, rv_m);
    check("flush", bus.flush, rv_m);
    check("br_cnt", bus.br_cnt, br_m);
    check("miss_cnt", bus.miss_cnt, miss_m);
    check("pred_after_edge", bus.if_pred_taken, bht_m[ix][1]);
    if (rv_m) begin
      tick();
      check("redirect_clear", bus.redirect_valid, rv_m);
    end
  endtask

  // Scoreboard: each new redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (bus.redirect_valid && !prev_rv) begin
      if (exp_q.size() > 0) check("redirect_pc", bus.redirect_pc, exp_q.pop_front());
      else check("unexpected_redirect", bus.redirect_valid, 0);
      check("flush_at_redirect", bus.flush, 1);
    end
    prev_rv <= bus.redirect_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    prev_rv  = 0;
    rstn     = 0;
    clear_ex();
    bus.stall  = 0;
    bus.ex_pc  = 0;
    bus.ex_imm = 0;
    bus.ex_rs1 = 0;
    bus.if_pc  = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_redirect_valid", bus.redirect_valid, 0);
    check("rst_redirect_pc", bus.redirect_pc, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_br_cnt", bus.br_cnt, 0);
    check("rst_miss_cnt", bus.miss_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      bus.if_pc = 64'h1000 + 64'(i * 4);
      #1;
      check("rst_pred", bus.if_pred_taken, 0);
    end
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;

    // Mispredicted BEQ out of reset, then train/saturate index 0.
    issue(0, 64'h1000, 64'h40, 0, 1, 0);
    issue(0, 64'h1000, 64'h40, 0, 1, 1);
    issue(0, 64'h1000, 64'h40, 0, 0, 1);
    issue(0, 64'h1000, 64'h40, 0, 0, 1);
    issue(0, 64'h1000, 64'h40, 0, 0, 0);
    issue(0, 64'h1000, 64'h40, 0, 0, 0);

    // JALR with odd sum: low bit cleared, BHT and br_cnt untouched.
    issue(2, 64'h1000, 64'h10, 64'h2003, 0, 0);
    issue(1, 64'h1000, 64'h80, 0, 0, 0);
    // Correct predictions: no redirect.
    issue(0, 64'h3000, 64'h100, 0, 0, 0);
    issue(0, 64'h3004, 64'h100, 0, 1, 1);
    // Multi-hot decode: JALR wins.
    issue(0, 64'h3010, 64'h8, 64'h5000, 1, 1);
    bus.ex_valid = 1; bus.ex_is_branch = 1; bus.ex_is_jalr = 1;
    bus.ex_pc = 64'h3010; bus.ex_imm = 64'h8; bus.ex_rs1 = 64'h5000; bus.cmp_res = 0;
    tick();
    clear_ex();
    check("multihot_rv", bus.redirect_valid, rv_m);
    tick();

    // Squash and stall hold.
    bus.ex_valid = 1; bus.ex_is_branch = 1; bus.ex_pc = 64'h3008; bus.ex_imm = 64'h100;
    bus.cmp_res = 1; bus.ex_pred_taken = 0;
    tick();
    clear_ex();
    bus.ex_valid = 1; bus.ex_is_jal = 1; bus.ex_pc = 64'h4000; bus.ex_imm = 64'h20;
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", bus.redirect_valid, 1);
      check("hold_pc", bus.redirect_pc, 64'h3108);
      tick();
    end
    bus.stall = 0;
    check("hold_valid_n4", bus.redirect_valid, 1);
    check("hold_pc_n4", bus.redirect_pc, 64'h3108);
    tick();
    check("clear_n5", bus.redirect_valid, 0);
    clear_ex();
    tick();
    check("squash_no_redirect", bus.redirect_valid, 0);
    check("squash_br_cnt", bus.br_cnt, br_m);

    // Collision on index 0: read in the update cycle sees the old counter.
    issue(0, 64'h1000, 64'h40, 0, 1, 1);
    issue(0, 64'h1000, 64'h40, 0, 1, 0);

    // miss_cnt wrap.
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_q;
    miss_m = 32'hFFFF_FFFF;
    check("miss_preload", bus.miss_cnt, miss_m);
    issue(0, 64'h2000, 64'h40, 0, 1, 0);
    check("miss_wrapped", bus.miss_cnt, 0);

    // Reset while a redirect is pending.
    bus.ex_valid = 1; bus.ex_is_branch = 1; bus.ex_pc = 64'h5000; bus.ex_imm = 64'h40;
    bus.cmp_res = 1; bus.ex_pred_taken = 0;
    tick();
    clear_ex();
    check("pre_reset_rv", bus.redirect_valid, 1);
    @(negedge clk);
    #1;
    rstn = 0;
    #1;
    model_reset();
    bus.if_pc = 64'h1000;
    #1;
    check("mid_rst_rv", bus.redirect_valid, 0);
    check("mid_rst_pc", bus.redirect_pc, 0);
    check("mid_rst_flush", bus.flush, 0);
    check("mid_rst_br", bus.br_cnt, 0);
    check("mid_rst_miss", bus.miss_cnt, 0);
    check("mid_rst_pred", bus.if_pred_taken, 0);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    issue(0, 64'h1000, 64'h40, 0, 1, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
